// File: rtl/vram_blit_pkg.sv
// Shared constants, source codes and FSM state type for the VRAM tile blitter.
// Optional feature macro used by the blitter: BLIT_COLORKEY_EN.
package vram_blit_pkg;

  localparam int SCR_W = 320;
  localparam int SCR_H = 240;

  localparam int TILE_DIM = 32;
  localparam int TILE_PIX = 1024;

  localparam logic [1:0] SRC_BACKGROUND = 2'd0;
  localparam logic [1:0] SRC_CHARACTER  = 2'd1;
  localparam logic [1:0] SRC_CI         = 2'd2;
  localparam logic [1:0] SRC_WALL       = 2'd3;

  localparam logic [11:0] COLOR_KEY = 12'hF0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } blit_state_e;

endpackage

// File: rtl/vram_blit_ctrl_if.sv
// Bus bundle between the CPU-side decoder / tile ROMs / VRAM port A and the blitter.
// The slave modport is the blitter; the master modport is everything around it.
interface vram_blit_ctrl_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_src;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_key_en;

  logic [9:0]  rom_addr;
  logic [11:0] bg_data;
  logic [11:0] chr_data;
  logic [11:0] ci_data;
  logic [11:0] wall_data;

  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [11:0] cpu_data;

  logic        vram_we;
  logic [17:0] vram_addr;
  logic [11:0] vram_data;

  logic        busy;
  logic        done;

  modport slave (
    input  cmd_valid, cmd_src, cmd_x, cmd_y, cmd_key_en,
    input  bg_data, chr_data, ci_data, wall_data,
    input  cpu_we, cpu_addr, cpu_data,
    output cmd_ready, rom_addr,
    output vram_we, vram_addr, vram_data,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_src, cmd_x, cmd_y, cmd_key_en,
    output bg_data, chr_data, ci_data, wall_data,
    output cpu_we, cpu_addr, cpu_data,
    input  cmd_ready, rom_addr,
    input  vram_we, vram_addr, vram_data,
    input  busy, done
  );

endinterface

// File: rtl/vram_blit_addr_gen.sv
// Tile walk address generator: row/col counters, running line base address,
// screen-edge clipping and the hold while a CPU write owns the VRAM port.
module vram_blit_addr_gen
  import vram_blit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  input  logic        stall,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  output logic [4:0]  row,
  output logic [4:0]  col,
  output logic [17:0] pix_addr,
  output logic        in_screen,
  output logic        issue,
  output logic        all_issued
);

  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [17:0] line_base_q, line_base_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        all_issued_q, all_issued_d;
  logic [17:0] start_base;

  // Top-left VRAM address of the tile, computed from the raw command fields.
  assign start_base = 18'(cmd_y) * 18'(SCR_W) + 18'(cmd_x);

  // A pixel leaves stage 0 only when running, not stalled and not yet finished.
  assign issue = run && !stall && !all_issued_q;

  assign row        = row_q;
  assign col        = col_q;
  assign all_issued = all_issued_q;
  assign pix_addr   = line_base_q + 18'(col_q);
  assign in_screen  = ((10'(x_q) + 10'(col_q)) < 10'(SCR_W)) &&
                      ((9'(y_q) + 9'(row_q)) < 9'(SCR_H));

  // Next-state of the walk: load on accept, step one pixel per issue, hold otherwise.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    line_base_d  = line_base_q;
    x_d          = x_q;
    y_d          = y_q;
    all_issued_d = all_issued_q;
    if (start) begin
      row_d        = 5'd0;
      col_d        = 5'd0;
      line_base_d  = start_base;
      x_d          = cmd_x;
      y_d          = cmd_y;
      all_issued_d = 1'b0;
    end else if (issue) begin
      col_d = col_q + 5'd1;
      if (col_q == 5'(TILE_DIM - 1)) begin
        row_d       = row_q + 5'd1;
        line_base_d = line_base_q + 18'(SCR_W);
        if (row_q == 5'(TILE_DIM - 1)) begin
          all_issued_d = 1'b1;
        end
      end
    end
  end

  // Walk state registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= 5'd0;
      col_q        <= 5'd0;
      line_base_q  <= 18'd0;
      x_q          <= 9'd0;
      y_q          <= 8'd0;
      all_issued_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      line_base_q  <= line_base_d;
      x_q          <= x_d;
      y_q          <= y_d;
      all_issued_q <= all_issued_d;
    end
  end

endmodule

// File: rtl/vram_blit_ctrl.sv
// Tile blitter and VRAM port A write arbiter. CPU writes always win and stall
// the blit for the cycle they occupy. Define BLIT_COLORKEY_EN to enable
// colour-key skipping of pixels equal to COLOR_KEY.
module vram_blit_ctrl
  import vram_blit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  vram_blit_ctrl_if.slave bus
);

  blit_state_e state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic        key_en_q, key_en_d;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_qual_q, s1_qual_d;
  logic [17:0] s1_addr_q, s1_addr_d;
  logic [11:0] s1_data_q, s1_data_d;

  logic        start;
  logic        run;
  logic        issue;
  logic        all_issued;
  logic        in_screen;
  logic [4:0]  row;
  logic [4:0]  col;
  logic [17:0] pix_addr;
  logic [11:0] rom_pix;
  logic        key_hit;

  vram_blit_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .run        (run),
    .stall      (bus.cpu_we),
    .cmd_x      (bus.cmd_x),
    .cmd_y      (bus.cmd_y),
    .row        (row),
    .col        (col),
    .pix_addr   (pix_addr),
    .in_screen  (in_screen),
    .issue      (issue),
    .all_issued (all_issued)
  );

  assign bus.rom_addr = {row, col};

  // Select the pixel from the tile ROM chosen by the latched source code.
  always_comb begin
    rom_pix = bus.bg_data;
    case (src_q)
      SRC_BACKGROUND: rom_pix = bus.bg_data;
      SRC_CHARACTER:  rom_pix = bus.chr_data;
      SRC_CI:         rom_pix = bus.ci_data;
      default:        rom_pix = bus.wall_data;
    endcase
  end

`ifdef BLIT_COLORKEY_EN
  assign key_hit = key_en_q && (rom_pix == COLOR_KEY);
`else
  logic unused_key_en;
  assign unused_key_en = key_en_q;
  assign key_hit       = 1'b0;
`endif

  // FSM next state and handshake/status outputs; RUN ends once the last pixel drains.
  always_comb begin
    state_d       = state_q;
    start         = 1'b0;
    run           = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (all_issued && !bus.cpu_we) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and stage-1 pixel register; everything holds while the CPU writes.
  always_comb begin
    src_d      = src_q;
    key_en_d   = key_en_q;
    s1_valid_d = s1_valid_q;
    s1_qual_d  = s1_qual_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    if (start) begin
      src_d    = bus.cmd_src;
      key_en_d = bus.cmd_key_en;
    end
    if (!run) begin
      s1_valid_d = 1'b0;
    end else if (!bus.cpu_we) begin
      s1_valid_d = issue;
      if (issue) begin
        s1_addr_d = pix_addr;
        s1_data_d = rom_pix;
        s1_qual_d = in_screen && !key_hit;
      end
    end
  end

  // Port A mux: the CPU strobe takes the port in the same cycle it appears.
  always_comb begin
    bus.vram_we   = s1_valid_q && s1_qual_q;
    bus.vram_addr = s1_addr_q;
    bus.vram_data = s1_data_q;
    if (bus.cpu_we) begin
      bus.vram_we   = 1'b1;
      bus.vram_addr = bus.cpu_addr;
      bus.vram_data = bus.cpu_data;
    end
  end

  // State, command and stage-1 registers; reset abandons any blit in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= SRC_BACKGROUND;
      key_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_qual_q  <= 1'b0;
      s1_addr_q  <= 18'd0;
      s1_data_q  <= 12'd0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      key_en_q   <= key_en_d;
      s1_valid_q <= s1_valid_d;
      s1_qual_q  <= s1_qual_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
    end
  end

endmodule

// File: tb/tb_vram_blit_ctrl.sv
// Scoreboard bench for vram_blit_ctrl: a tile-level reference model queues
// every expected VRAM write, and a negedge monitor pops and compares them.
module tb_vram_blit_ctrl;
  import vram_blit_pkg::*;

`ifdef BLIT_COLORKEY_EN
  localparam bit KEY_BUILD = 1'b1;
`else
  localparam bit KEY_BUILD = 1'b0;
`endif

  // Accept-to-done distance with no stalls, and the gap to the next accept
  // (one DONE cycle, then one IDLE cycle with cmd_ready high).
  localparam int DONE_LAT   = 1025;
  localparam int ACCEPT_GAP = DONE_LAT + 2;

  typedef struct packed {
    logic [17:0] addr;
    logic [11:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vram_blit_ctrl_if bus ();

  vram_blit_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] rom_mem [4][1024];
  assign bus.bg_data   = rom_mem[0][bus.rom_addr];
  assign bus.chr_data  = rom_mem[1][bus.rom_addr];
  assign bus.ci_data   = rom_mem[2][bus.rom_addr];
  assign bus.wall_data = rom_mem[3][bus.rom_addr];

  wr_t blit_q[$];
  wr_t cpu_q[$];
  wr_t mon_e;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int done_exp = 0;
  bit done_pending = 1'b0;
  int done_seen = 0;
  int blit_writes = 0;
  int exp_count = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: walk the tile in raster order and keep each on-screen, non-keyed pixel.
  task automatic build_expect(input int src, input int x0, input int y0, input bit key);
    exp_count = 0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        int x;
        int y;
        logic [11:0] pix;
        wr_t w;
        x = x0 + c;
        y = y0 + r;
        pix = rom_mem[src][r * 32 + c];
        if (x < 320 && y < 240 && !(KEY_BUILD && key && pix == 12'hF0F)) begin
          w.addr = 18'(y * 320 + x);
          w.data = pix;
          blit_q.push_back(w);
          exp_count++;
        end
      end
    end
  endtask

  task automatic fill_identity();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 1024; a++) rom_mem[s][a] = 12'(a);
  endtask

  task automatic fill_random();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 1024; a++) rom_mem[s][a] = 12'($urandom);
  endtask

  task automatic fill_key();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 1024; a++) begin
        if (a % 2 == 0) rom_mem[s][a] = 12'hF0F;
        else begin
          rom_mem[s][a] = 12'($urandom);
          if (rom_mem[s][a] == 12'hF0F) rom_mem[s][a] = 12'h000;
        end
      end
  endtask

  // Issue one command (called just after a rising edge); returns the accept edge number.
  task automatic apply_stimulus(input int src, input int x, input int y, input bit key,
                                input bit keep_valid, output int accept_edge);
    int guard;
    bus.cmd_src    = 2'(src);
    bus.cmd_x      = 9'(x);
    bus.cmd_y      = 8'(y);
    bus.cmd_key_en = key;
    bus.cmd_valid  = 1'b1;
    guard = 0;
    accept_edge = -1;
    while (!bus.cmd_ready && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.cmd_ready) begin
      check_output("accept_timeout", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      accept_edge  = cycle + 1;
      build_expect(src, x, y, key);
      done_exp     = accept_edge + DONE_LAT;
      done_pending = 1'b1;
      blit_writes  = 0;
      @(posedge clk);
      #1;
      if (!keep_valid) bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int guard;
    int start_seen;
    guard = 0;
    start_seen = done_seen;
    while (done_seen == start_seen && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (done_seen == start_seen) check_output("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_writes(input int n);
    int guard;
    guard = 0;
    while (blit_writes < n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (blit_writes < n) check_output("write_progress_timeout", 64'(blit_writes), 64'(n));
  endtask

  // Monitor: pop and compare every VRAM write, check done timing and the busy handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) check_output("cmd_ready_while_busy", 64'(bus.cmd_ready), 64'd0);
      if (bus.vram_we) begin
        if (bus.cpu_we) begin
          if (cpu_q.size() == 0) check_output("cpu_write_unexpected", 64'd1, 64'd0);
          else begin
            mon_e = cpu_q.pop_front();
            check_output("cpu_write", {34'd0, bus.vram_addr, bus.vram_data}, {34'd0, mon_e});
          end
        end else begin
          if (blit_q.size() == 0) check_output("blit_write_extra", {34'd0, bus.vram_addr, bus.vram_data}, 64'd0);
          else begin
            mon_e = blit_q.pop_front();
            check_output("blit_write", {34'd0, bus.vram_addr, bus.vram_data}, {34'd0, mon_e});
          end
          blit_writes++;
        end
      end
      if (bus.done) begin
        if (!done_pending) check_output("done_unexpected", 64'd1, 64'd0);
        else begin
          check_output("done_cycle", 64'(cycle), 64'(done_exp));
          check_output("blit_write_count", 64'(blit_writes), 64'(exp_count));
          check_output("blit_queue_drained", 64'(blit_q.size()), 64'd0);
          done_pending = 1'b0;
        end
        done_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1;
    int e2;
    wr_t w;
    bus.cmd_valid  = 1'b0;
    bus.cmd_src    = 2'd0;
    bus.cmd_x      = 9'd0;
    bus.cmd_y      = 8'd0;
    bus.cmd_key_en = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 18'd0;
    bus.cpu_data   = 12'd0;
    fill_identity();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_vram_we", 64'(bus.vram_we), 64'd0);
    check_output("reset_rom_addr", 64'(bus.rom_addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle CPU write passes straight through.
    w.addr = 18'h2_1234 & 18'h1FFFF;
    w.data = 12'h5A5;
    cpu_q.push_back(w);
    bus.cpu_we = 1'b1; bus.cpu_addr = w.addr; bus.cpu_data = w.data;
    @(posedge clk);
    #1;
    bus.cpu_we = 1'b0;

    // Full tile at the origin with address-valued ROM.
    apply_stimulus(0, 0, 0, 1'b0, 1'b0, e1);
    wait_done();

    // Bottom-right corner: clipped to 20x20.
    fill_random();
    apply_stimulus(3, 300, 220, 1'b0, 1'b0, e1);
    wait_done();

    // Three CPU write cycles in the middle of a blit.
    apply_stimulus(1, 40, 50, 1'b0, 1'b0, e1);
    wait_writes(100);
    w.addr = 18'h100;
    w.data = 12'hABC;
    repeat (3) cpu_q.push_back(w);
    done_exp += 3;
    bus.cpu_we = 1'b1; bus.cpu_addr = w.addr; bus.cpu_data = w.data;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.cpu_we = 1'b0;
    wait_done();

    // Colour key on even columns.
    fill_key();
    apply_stimulus(2, 100, 100, 1'b1, 1'b0, e1);
    wait_done();

    // Random placements and sources, some partly or fully off screen.
    for (int i = 0; i < 3; i++) begin
      fill_random();
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 340)),
                     int'($urandom_range(0, 250)), 1'($urandom), 1'b0, e1);
      wait_done();
    end

    // Reset in the middle of a blit.
    fill_identity();
    apply_stimulus(0, 10, 10, 1'b0, 1'b0, e1);
    wait_writes(500);
    rst_n = 1'b0;
    #1;
    check_output("midreset_vram_we", 64'(bus.vram_we), 64'd0);
    check_output("midreset_busy", 64'(bus.busy), 64'd0);
    blit_q.delete();
    done_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("postreset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    apply_stimulus(1, 64, 32, 1'b0, 1'b0, e1);
    wait_done();

    // Held cmd_valid carrying two commands back to back.
    fill_random();
    apply_stimulus(2, 5, 7, 1'b0, 1'b1, e1);
    apply_stimulus(0, 200, 100, 1'b0, 1'b0, e2);
    check_output("second_accept_gap", 64'(e2 - e1), 64'(ACCEPT_GAP));
    wait_done();

    repeat (3) @(posedge clk);
    check_output("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
